pc_fetch_gen: RTL and testbench

- Parametrised program-counter generator, the successor to the single-width PC register.
- Produces the fetch address and the request strobe toward instruction memory.
- Supports a ready/valid fetch handshake and configurable address width, reset vector and step.
- Buffers a branch redirect that arrives while fetch cannot advance, so it is never lost.
- Sits at the head of the IF stage; consumes stall/flush from the pipeline controller and redirects from EX.

---
 rtl/pc_fetch_gen_pkg.sv | 21 ++
 rtl/pc_fetch_gen_if.sv | 13 +
 rtl/pc_fetch_gen_redirect_buf.sv | 27 ++
 rtl/pc_fetch_gen.sv | 118 +++++++++++
 tb/tb_pc_fetch_gen.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_gen_pkg.sv
// Shared constants, state encodings and defaults for the PC fetch generator.
// The optional misalignment check is enabled by defining PC_MISALIGN_CHK_EN.
package pc_fetch_gen_pkg;

  localparam int STALL_BUS_W = 6;

  localparam logic TRUE_V       = 1'b1;
  localparam logic FALSE_V      = 1'b0;
  localparam logic BRANCH       = 1'b1;
  localparam logic NOT_BRANCH   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Fetch request channel between the PC generator and instruction memory.
// ce is the request valid, inst_ready_i the accept; a request transfers on a
// clock where both are high, and pc must hold while ce=1 and inst_ready_i=0.
interface pc_fetch_gen_if #(
  parameter int AW = 32
);
  logic [AW-1:0] pc;
  logic          ce;
  logic          inst_ready_i;

  modport master (output pc, output ce, input inst_ready_i);
  modport slave  (input pc, input ce, output inst_ready_i);
endinterface

// File: rtl/pc_fetch_gen_redirect_buf.sv
// Pending branch-target register: holds a redirect that arrived while fetch
// could not advance. Clear wins over capture; a new capture overwrites the old.
module pc_redirect_buf #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic          clear,
  input  logic [AW-1:0] target_in,
  output logic [AW-1:0] target,
  output logic          valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target <= '0;
      valid  <= 1'b0;
    end else if (clear) begin
      valid  <= 1'b0;
    end else if (capture) begin
      target <= target_in;
      valid  <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// Program-counter generator at the head of IF: sequential stepping, flush and
// branch redirects, and buffering of redirects while fetch is blocked.
// Defining PC_MISALIGN_CHK_EN adds misalign_o and aligns loaded targets.
module pc_fetch_gen
  import pc_fetch_gen_pkg::*;
#(
  parameter int              AW           = 32,
  parameter int              STALL_W      = STALL_BUS_W,
  parameter logic [AW-1:0]   RESET_VECTOR = AW'(DEFAULT_RESET_VECTOR),
  parameter int              STEP         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [AW-1:0]         exception_handle_addr_i,
  input  logic                  branch_flag_i,
  input  logic [AW-1:0]         branch_target_address_i,
  pc_fetch_gen_if.master        fetch,
  output logic                  redirect_pending_o,
  output pc_state_e             state_o
`ifdef PC_MISALIGN_CHK_EN
  ,output logic                 misalign_o
`endif
);

  pc_state_e     state;
  logic [AW-1:0] pc_q;
  logic          ce_q;
  logic          adv;
  logic          load_tgt;
  logic [AW-1:0] tgt;
  logic [AW-1:0] pend_target;
  logic          pend_valid;
  logic          buf_capture;
  logic          buf_clear;
  logic          unused_stall;

  // Only bit 0 of the stall vector belongs to the PC stage.
  assign unused_stall = ^stall;

  assign adv = ce_q & fetch.inst_ready_i & ~stall[0];

  // Redirect source selection; flush outranks everything, then a live branch,
  // then an older buffered target.
  always_comb begin
    load_tgt = FALSE_V;
    tgt      = '0;
    if (flush) begin
      load_tgt = TRUE_V;
      tgt      = exception_handle_addr_i;
    end else if (adv && branch_flag_i == BRANCH) begin
      load_tgt = TRUE_V;
      tgt      = branch_target_address_i;
    end else if (adv && pend_valid) begin
      load_tgt = TRUE_V;
      tgt      = pend_target;
    end
  end

  assign buf_capture = (state == ST_RUN) & ~flush & ~adv & branch_flag_i;
  assign buf_clear   = (state == ST_RUN) & (flush | adv);

  pc_redirect_buf #(.AW(AW)) u_redirect_buf (
    .clk       (clk),
    .rst       (rst),
    .capture   (buf_capture),
    .clear     (buf_clear),
    .target_in (branch_target_address_i),
    .target    (pend_target),
    .valid     (pend_valid)
  );

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [AW-1:0] ALIGN_MASK = AW'(STEP - 1);
  logic mis_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_BOOT;
      pc_q  <= RESET_VECTOR;
      ce_q  <= CHIP_DISABLE;
`ifdef PC_MISALIGN_CHK_EN
      mis_q <= FALSE_V;
`endif
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
          ce_q  <= CHIP_ENABLE;
        end
        default: begin
          ce_q <= CHIP_ENABLE;
`ifdef PC_MISALIGN_CHK_EN
          mis_q <= load_tgt & (|(tgt & ALIGN_MASK));
          if (load_tgt)
            pc_q <= tgt & ~ALIGN_MASK;
`else
          if (load_tgt)
            pc_q <= tgt;
`endif
          else if (adv)
            pc_q <= pc_q + AW'(STEP);
        end
      endcase
    end
  end

  assign fetch.pc           = pc_q;
  assign fetch.ce           = ce_q;
  assign redirect_pending_o = pend_valid;
  assign state_o            = state;
`ifdef PC_MISALIGN_CHK_EN
  assign misalign_o         = mis_q;
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: a 32-bit instance for the main sequence and
// a 16-bit instance for wrap-around, boot behaviour and mid-run reset.
module tb_pc_fetch_gen;
  import pc_fetch_gen_pkg::*;

  logic        clk;
  logic        rst_a;
  logic        rst_b;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] exc_addr;
  logic        branch;
  logic [31:0] br_tgt;
  logic        ready;
  logic        pend_a;
  logic        pend_b;
  pc_state_e   st_a;
  pc_state_e   st_b;
`ifdef PC_MISALIGN_CHK_EN
  logic        mis_a;
  logic        mis_b;
`endif

  int n_total = 0;
  int n_pass  = 0;

  pc_fetch_gen_if #(.AW(32)) if_a ();
  pc_fetch_gen_if #(.AW(16)) if_b ();

  assign if_a.inst_ready_i = ready;
  assign if_b.inst_ready_i = ready;

  pc_fetch_gen #(.AW(32), .STALL_W(6), .RESET_VECTOR(32'h0), .STEP(4)) dut_a (
    .clk                     (clk),
    .rst                     (rst_a),
    .stall                   (stall),
    .flush                   (flush),
    .exception_handle_addr_i (exc_addr),
    .branch_flag_i           (branch),
    .branch_target_address_i (br_tgt),
    .fetch                   (if_a.master),
    .redirect_pending_o      (pend_a),
    .state_o                 (st_a)
`ifdef PC_MISALIGN_CHK_EN
    ,.misalign_o             (mis_a)
`endif
  );

  pc_fetch_gen #(.AW(16), .STALL_W(6), .RESET_VECTOR(16'h0), .STEP(4)) dut_b (
    .clk                     (clk),
    .rst                     (rst_b),
    .stall                   (stall),
    .flush                   (flush),
    .exception_handle_addr_i (exc_addr[15:0]),
    .branch_flag_i           (branch),
    .branch_target_address_i (br_tgt[15:0]),
    .fetch                   (if_b.master),
    .redirect_pending_o      (pend_b),
    .state_o                 (st_b)
`ifdef PC_MISALIGN_CHK_EN
    ,.misalign_o             (mis_b)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    stall = '0; flush = 1'b0; exc_addr = '0;
    branch = 1'b0; br_tgt = '0; ready = 1'b1;
    tick(); tick();

    chk("rst_pc",    if_a.pc, 32'h0);
    chk("rst_ce",    32'(if_a.ce), 32'h0);
    chk("rst_pend",  32'(pend_a), 32'h0);
    chk("rst_state", 32'(st_a), 32'(ST_BOOT));

    // release reset: one BOOT clock with ce=0, then stepping
    @(negedge clk); rst_a = 1'b1; #1;
    chk("boot_ce", 32'(if_a.ce), 32'h0);
    tick(); chk("run_ce", 32'(if_a.ce), 32'h1); chk("run_pc0", if_a.pc, 32'h0);
    chk("run_state", 32'(st_a), 32'(ST_RUN));
    tick(); chk("seq_4",  if_a.pc, 32'h4);
    tick(); chk("seq_8",  if_a.pc, 32'h8);
    tick(); chk("seq_12", if_a.pc, 32'hC);

    // memory not ready holds the request
    flush = 1'b1; exc_addr = 32'h100;
    tick(); chk("flush_100", if_a.pc, 32'h100);
    flush = 1'b0; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("nrdy_pc", if_a.pc, 32'h100); chk("nrdy_ce", 32'(if_a.ce), 32'h1);
    end
    ready = 1'b1;
    tick(); chk("rdy_104", if_a.pc, 32'h104);

    // branch while stalled is buffered
    stall = 6'b000001; branch = 1'b1; br_tgt = 32'h200;
    tick(); chk("stl_br_pend", 32'(pend_a), 32'h1); chk("stl_br_pc", if_a.pc, 32'h104);
    branch = 1'b0;
    tick(); chk("stl_hold_pc", if_a.pc, 32'h104);
    stall = 6'b0;
    tick(); chk("pend_apply", if_a.pc, 32'h200); chk("pend_clr", 32'(pend_a), 32'h0);

    // youngest pending branch wins
    stall = 6'b000001; branch = 1'b1; br_tgt = 32'h200; tick();
    br_tgt = 32'h300; tick();
    branch = 1'b0; stall = 6'b0;
    tick(); chk("pend_young", if_a.pc, 32'h300); chk("pend_young_clr", 32'(pend_a), 32'h0);

    // flush beats a same-cycle branch
    flush = 1'b1; exc_addr = 32'h8000_0020; branch = 1'b1; br_tgt = 32'h400;
    tick(); chk("flush_exc", if_a.pc, 32'h8000_0020); chk("flush_pend", 32'(pend_a), 32'h0);
    flush = 1'b0; branch = 1'b0;
    tick(); chk("flush_seq", if_a.pc, 32'h8000_0024);

    // flush while stalled discards a pending target
    stall = 6'b000001; branch = 1'b1; br_tgt = 32'h500; tick();
    branch = 1'b0; flush = 1'b1; exc_addr = 32'h40;
    tick(); chk("flush_stl_pc", if_a.pc, 32'h40); chk("flush_stl_pend", 32'(pend_a), 32'h0);
    flush = 1'b0; stall = 6'b0;
    tick(); chk("flush_stl_seq", if_a.pc, 32'h44);

    // live branch overrides an older pending target
    stall = 6'b000001; branch = 1'b1; br_tgt = 32'h600; tick();
    stall = 6'b0; br_tgt = 32'h700;
    tick(); chk("live_br", if_a.pc, 32'h700); chk("live_br_pend", 32'(pend_a), 32'h0);
    branch = 1'b0;

    // upper stall bits do not freeze the PC
    stall = 6'b111110;
    tick(); chk("upper_stall", if_a.pc, 32'h704);
    stall = 6'b0;

`ifdef PC_MISALIGN_CHK_EN
    branch = 1'b1; br_tgt = 32'h202;
    tick(); chk("mis_pc", if_a.pc, 32'h200); chk("mis_set", 32'(mis_a), 32'h1);
    branch = 1'b0;
    tick(); chk("mis_clr", 32'(mis_a), 32'h0); chk("mis_seq", if_a.pc, 32'h204);
`endif

    // asynchronous reset with a pending target
    stall = 6'b000001; branch = 1'b1; br_tgt = 32'h900;
    tick(); chk("pre_rst_pend", 32'(pend_a), 32'h1);
    branch = 1'b0;
    @(posedge clk); #2; rst_a = 1'b0; #1;
    chk("async_pc_a",   if_a.pc, 32'h0);
    chk("async_ce_a",   32'(if_a.ce), 32'h0);
    chk("async_pend_a", 32'(pend_a), 32'h0);
    stall = 6'b0;

    // 16-bit instance: BOOT ignores flush, then wrap-around
    flush = 1'b1; exc_addr = 32'h1234;
    @(negedge clk); rst_b = 1'b1;
    tick(); chk("b_boot_pc", 32'(if_b.pc), 32'h0); chk("b_boot_ce", 32'(if_b.ce), 32'h1);
    exc_addr = 32'hFFFC;
    tick(); chk("b_flush_fffc", 32'(if_b.pc), 32'hFFFC);
    flush = 1'b0;
    tick(); chk("b_wrap", 32'(if_b.pc), 32'h0);
    tick(); chk("b_after_wrap", 32'(if_b.pc), 32'h4);
    @(posedge clk); #2; rst_b = 1'b0; #1;
    chk("b_async_pc",    32'(if_b.pc), 32'h0);
    chk("b_async_ce",    32'(if_b.ce), 32'h0);
    chk("b_async_state", 32'(st_b), 32'(ST_BOOT));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
